// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

   localparam int DWIDTH = 32;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } size_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_LD,
      S_RESP
   } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane extract/extend for loads and lane merge for sub-word stores (little-endian lanes).
module lsu_align
   import lsu_pkg::*;
(
   input  size_t             size,
   input  logic [1:0]        lane,
   input  logic              sgn,
   input  logic [DWIDTH-1:0] rdata,
   input  logic [DWIDTH-1:0] wdata,
   output logic [DWIDTH-1:0] ext,
   output logic [DWIDTH-1:0] merged
);

   logic [7:0]  bsel;
   logic [15:0] hsel;

   always_comb begin
      bsel   = rdata[{lane, 3'b000} +: 8];
      hsel   = lane[1] ? rdata[31:16] : rdata[15:0];
      ext    = rdata;
      merged = wdata;
      case (size)
         SZ_BYTE: begin
            ext = {{24{sgn & bsel[7]}}, bsel};
            merged = rdata;
            merged[{lane, 3'b000} +: 8] = wdata[7:0];
         end
         SZ_HALF: begin
            ext = {{16{sgn & hsel[15]}}, hsel};
            merged = rdata;
            merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
         end
         default: begin
            ext    = rdata;
            merged = wdata;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: request FSM, read-modify-write for sub-word stores, registered response.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int AWIDTH  = 32,
   parameter int ALENGTH = 128
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [AWIDTH-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              mem_we,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   lsu_state_t        st;
   logic              r_we;
   logic              r_sgn;
   size_t             r_size;
   logic [1:0]        r_lane;
   logic [AWIDTH-1:0] r_widx;
   logic [31:0]       r_wdata;

   logic [AWIDTH-1:0] widx;
   logic              req_bad;
   logic [31:0]       ext;
   logic [31:0]       merged;

   assign widx = req_addr >> 2;

   always_comb begin
      req_bad = 1'b0;
      case (req_size)
         2'b00:   req_bad = 1'b0;
         2'b01:   req_bad = req_addr[0];
         2'b10:   req_bad = |req_addr[1:0];
         default: req_bad = 1'b1;
      endcase
      if (widx >= AWIDTH'(ALENGTH)) req_bad = 1'b1;
   end

   assign req_ready = (st == S_IDLE) && rst_n;
   assign mem_we    = (st == S_WR) && rst_n;
   assign mem_addr  = r_widx;
   assign mem_wdata = (st != S_WR)      ? '0 :
                      (r_size == SZ_WORD) ? r_wdata : merged;

   lsu_align u_align (
      .size   (r_size),
      .lane   (r_lane),
      .sgn    (r_sgn),
      .rdata  (mem_rdata),
      .wdata  (r_wdata),
      .ext    (ext),
      .merged (merged)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st        <= S_IDLE;
         r_we      <= 1'b0;
         r_sgn     <= 1'b0;
         r_size    <= SZ_BYTE;
         r_lane    <= '0;
         r_widx    <= '0;
         r_wdata   <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (st)
            S_IDLE: if (req_valid) begin
               r_we    <= req_we;
               r_sgn   <= req_signed;
               r_size  <= size_t'(req_size);
               r_lane  <= req_addr[1:0];
               r_widx  <= widx;
               r_wdata <= req_wdata;
               if (req_bad) begin
                  st        <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
               end else if (req_we && req_size == 2'b10) begin
                  st <= S_WR;
               end else begin
                  st <= S_RD;
               end
            end
            S_RD: st <= r_we ? S_WR : S_LD;
            S_WR: begin
               st        <= S_RESP;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
            end
            S_LD: begin
               st        <= S_RESP;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_rdata <= ext;
            end
            S_RESP:  st <= S_IDLE;
            default: st <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a synchronous-read 128-word memory model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;

   logic [31:0] mem [128];

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   load_store_unit #(.AWIDTH(32), .ALENGTH(128)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[6:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[6:0]];
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_wes;
   } vec_t;

   vec_t vecs[18];

   function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input int exp_lat, input int exp_wes);
      vec_t v;
      v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_wes = exp_wes;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic do_req(input int idx, input vec_t v);
      int lat;
      int wes;
      int wait_cyc;
      wait_cyc = 0;
      @(negedge clk);
      while (!req_ready && wait_cyc < 10) begin
         @(negedge clk);
         wait_cyc++;
      end
      check($sformatf("v%0d_ready", idx), 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = v.we; req_size = v.size; req_signed = v.sgn;
      req_addr = v.addr; req_wdata = v.wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      wes = 0;
      while (1) begin
         @(negedge clk);
         lat++;
         if (mem_we) wes++;
         if (rsp_valid || lat > 10) break;
      end
      check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
      check($sformatf("v%0d_rdata", idx), rsp_rdata, v.exp_rdata);
      check($sformatf("v%0d_err", idx), 32'(rsp_err), 32'(v.exp_err));
      check($sformatf("v%0d_mem_we_count", idx), 32'(wes), 32'(v.exp_wes));
   endtask

   initial begin
      int accepts;
      int rsps;
      int last_rsp;
      for (int i = 0; i < 128; i++) mem[i] = '0;

      vecs[0]  = mk(1, 2'b10, 0, 32'h010, 32'hDEADBEEF, 32'h0,        0, 2, 1);
      vecs[1]  = mk(0, 2'b10, 0, 32'h010, 32'h0,        32'hDEADBEEF, 0, 3, 0);
      vecs[2]  = mk(1, 2'b00, 0, 32'h011, 32'h0000005A, 32'h0,        0, 3, 1);
      vecs[3]  = mk(0, 2'b01, 1, 32'h012, 32'h0,        32'hFFFFDEAD, 0, 3, 0);
      vecs[4]  = mk(0, 2'b00, 0, 32'h011, 32'h0,        32'h0000005A, 0, 3, 0);
      vecs[5]  = mk(1, 2'b00, 0, 32'h013, 32'hFFFFFF80, 32'h0,        0, 3, 1);
      vecs[6]  = mk(0, 2'b00, 1, 32'h013, 32'h0,        32'hFFFFFF80, 0, 3, 0);
      vecs[7]  = mk(0, 2'b00, 0, 32'h013, 32'h0,        32'h00000080, 0, 3, 0);
      vecs[8]  = mk(0, 2'b10, 0, 32'h006, 32'h0,        32'h0,        1, 1, 0);
      vecs[9]  = mk(1, 2'b01, 0, 32'h003, 32'h0000FFFF, 32'h0,        1, 1, 0);
      vecs[10] = mk(0, 2'b11, 0, 32'h000, 32'h0,        32'h0,        1, 1, 0);
      vecs[11] = mk(1, 2'b10, 0, 32'h200, 32'h11111111, 32'h0,        1, 1, 0);
      vecs[12] = mk(1, 2'b01, 0, 32'h012, 32'hABCD1234, 32'h0,        0, 3, 1);
      vecs[13] = mk(0, 2'b01, 0, 32'h010, 32'h0,        32'h00005AEF, 0, 3, 0);
      vecs[14] = mk(0, 2'b01, 1, 32'h010, 32'h0,        32'h00005AEF, 0, 3, 0);
      vecs[15] = mk(1, 2'b10, 0, 32'h1FC, 32'hCAFEF00D, 32'h0,        0, 2, 1);
      vecs[16] = mk(0, 2'b10, 1, 32'h1FC, 32'h0,        32'hCAFEF00D, 0, 3, 0);
      vecs[17] = mk(0, 2'b01, 1, 32'h1FE, 32'h0,        32'hFFFFCAFE, 0, 3, 0);

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'(req_ready), 32'd1);

      for (int i = 0; i < 18; i++) do_req(i, vecs[i]);

      check("mem_word4", mem[4], 32'h12345AEF);
      check("mem_word0_untouched", mem[0], 32'h0);
      check("mem_word1_untouched", mem[1], 32'h0);
      check("mem_word127", mem[127], 32'hCAFEF00D);

      // Back-to-back: req_valid held high across three word loads
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h010;
      accepts = 0; rsps = 0; last_rsp = -1;
      for (int c = 0; c < 20; c++) begin
         if (rsp_valid) begin
            rsps++;
            last_rsp = c;
            check($sformatf("b2b_rdata%0d", rsps), rsp_rdata, 32'h12345AEF);
            if (rsps == 3) begin
               req_valid = 1'b0;
               break;
            end
         end
         if (req_ready) accepts++;
         @(negedge clk);
      end
      req_valid = 1'b0;
      check("b2b_accepts", 32'(accepts), 32'd3);
      check("b2b_responses", 32'(rsps), 32'd3);
      check("b2b_last_rsp_cycle", 32'(last_rsp), 32'd11);
      repeat (3) @(negedge clk);
      check("b2b_no_extra_rsp", 32'(rsp_valid), 32'd0);

      // Reset during the WR cycle of a byte store
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h010; req_wdata = 32'h00000077;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rstwr_in_wr", 32'(mem_we), 32'd1);
      rst_n = 1'b0;
      #1 check("rstwr_mem_we_gated", 32'(mem_we), 32'd0);
      @(negedge clk);
      check("rstwr_no_rsp", 32'(rsp_valid), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rstwr_ready_after", 32'(req_ready), 32'd1);
      check("rstwr_no_rsp_after", 32'(rsp_valid), 32'd0);
      check("rstwr_mem_unchanged", mem[4], 32'h12345AEF);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the execute stage and the data memory. Accepts one byte/halfword/word access per handshake, converts byte addresses to word indices, and performs sub-word stores as read-modify-write. Sign- or zero-extends load data and returns one response per request. Drives the data memory's write-enable, address and write-data inputs and consumes its read data.

## Interface
- AWIDTH, 32, width of request byte address and of mem_addr
- ALENGTH, 128, data memory depth in 32-bit words
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept (IDLE only)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  sign-extend load data
- req_addr  in  AWIDTH  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal size or out-of-range
- mem_we  out  1  data memory write enable
- mem_addr  out  AWIDTH  word index (req_addr >> 2)
- mem_wdata  out  32  full-word write data
- mem_rdata  in  32  memory read data, valid one cycle after mem_addr

## Operation
- Handshake: accept on rising edge with req_valid && req_ready. Request fields are latched at accept. req_valid while busy is ignored, not queued.
- Byte lanes are little-endian: lane k = bits [8k+7:8k] at addr[1:0] = k. Halfword lane = addr[1].
- Error check at accept: misaligned (half with addr[0]=1, word with addr[1:0]≠0), size 11, or word index ≥ ALENGTH. Error goes to RESP with rsp_err=1. No memory read or write occurs.
- FSM states: IDLE, RD, WR, LD, RESP.
  - IDLE → RESP on error.
  - IDLE → WR for a word store.
  - IDLE → RD for a load or sub-word store.
  - RD → LD for a load; RD → WR for a sub-word store.
  - LD → RESP; WR → RESP; RESP → IDLE.
- RD: mem_addr = latched word index, mem_we=0.
- WR: mem_we=1. mem_wdata = req_wdata for a word store. For a sub-word store, mem_wdata = mem_rdata with the target lane(s) replaced by req_wdata[7:0] or [15:0] (combinational merge).
- LD: extract the lane from mem_rdata, then zero- or sign-extend (req_signed) into the rsp_rdata register.
- RESP: rsp_valid=1 for exactly one cycle. rsp_rdata and rsp_err are held until the next response.
- mem_we = (state==WR) && rst_n. req_ready = (state==IDLE) && rst_n.

## Timing
- Accept edge ends cycle N.
- Error: rsp_valid in N+1.
- Word store: mem_we in N+1, rsp_valid in N+2.
- Sub-word store: RD in N+1, mem_we in N+2, rsp_valid in N+3.
- Load: RD in N+1, capture in N+2, rsp_valid in N+3.
- Next accept is possible the cycle after RESP.
- Reset values: state IDLE; rsp_valid, rsp_err, mem_we = 0; rsp_rdata, mem_addr, mem_wdata = 0. req_ready = 0 while rst_n = 0, and 1 in the first cycle after release.
- Reset mid-operation: state returns to IDLE on that edge and no response is produced. If rst_n is low during WR, mem_we is gated to 0 and memory is unchanged.

## Structure
- Package lsu_pkg holds:
  - size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD)
  - lsu_state_t enum
  - localparam DWIDTH = 32
- Sub-module lsu_align (combinational) holds the lane extract/extend and lane merge logic. It is shared by the LD and WR paths.
- The top level holds the FSM and request/response registers. Pair it with a synchronous-read word memory model in the bench.

## Test plan
- Reset, store word 0xDEADBEEF @0x10, then load word @0x10 → mem_we once with mem_addr=4; store rsp in N+2, load rsp in N+3 with rsp_rdata=0xDEADBEEF, rsp_err=0.
- Store byte 0x5A @0x11 → RD then WR, word 4 becomes 0xDEAD5AEF. Load signed half @0x12 → 0xFFFFDEAD. Load unsigned byte @0x11 → 0x0000005A.
- Store byte 0x80 @0x13, then signed byte load @0x13 → 0xFFFFFF80; unsigned → 0x00000080.
- Load word @0x06, store half @0x03, size 11 @0x00, store word @0x200 → each gives rsp_err=1 in N+1, rsp_rdata=0, mem_we never asserted, memory unchanged.
- Hold req_valid high with back-to-back requests → each accepted only in IDLE, one rsp_valid pulse per request, no request dropped or duplicated.
- Assert rst_n=0 during the WR cycle of a byte store → mem_we=0, memory word unchanged, no rsp_valid, req_ready=1 the cycle after release.
